// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Burst mode is selected with the WR_ARB_BURST_EN macro (see fifo_wr_arbiter).
package fifo_wr_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF    = 4;
  localparam int MAX_BURST_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 8;

  // Next index after idx, wrapping modulo n.
  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or above start_i,
// wrapping around. Shared by the idle pick and the release re-arbitration.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     start_i,
  output logic [IDW-1:0]     pick_o,
  output logic               found_o
);

  // Scan all requesters starting at start_i and latch the first valid one.
  always_comb begin
    int   raw;
    int   idx;
    logic take;
    pick_o  = '0;
    found_o = 1'b0;
    raw     = 0;
    idx     = 0;
    take    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      raw     = int'(start_i) + i;
      idx     = (raw >= NUM_REQ) ? raw - NUM_REQ : raw;
      take    = !found_o && valid_i[idx];
      pick_o  = take ? IDW'(idx) : pick_o;
      found_o = found_o | take;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ
// requesters in the wclk domain. A grant is held for up to MAX_BURST beats
// when WR_ARB_BURST_EN is defined; otherwise every accepted beat releases
// the grant (per-beat round-robin). The FIFO full flag stalls the holder.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic                          full_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          w_en_o,
  output logic [DATA_WIDTH-1:0]         wdata_o,
  output logic                          grant_valid_o,
  output logic [IDW-1:0]                grant_id_o
);

  arb_state_e            state_q;
  logic [IDW-1:0]        grant_id_q;
  logic [IDW-1:0]        last_id_q;
  logic [IDW-1:0]        start_s;
  logic [IDW-1:0]        pick_s;
  logic                  found_s;
  logic                  busy_s;
  logic                  hold_valid_s;
  logic                  accept_s;
  logic                  last_beat_s;
  logic                  release_s;
  logic [DATA_WIDTH-1:0] gnt_data_s;

`ifdef WR_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] beat_cnt_q;
  assign last_beat_s = (beat_cnt_q == CW'(MAX_BURST - 1));
`else
  // Burst length collapses to one beat; MAX_BURST only has to be legal.
  assign last_beat_s = (MAX_BURST >= 1);
`endif

  assign busy_s       = (state_q == ARB_BUSY);
  assign hold_valid_s = req_valid_i[grant_id_q];
  assign accept_s     = busy_s & hold_valid_s & ~full_i;
  // A stall under full never releases; only a dropped valid or the last beat does.
  assign release_s    = busy_s & (~hold_valid_s | (accept_s & last_beat_s));
  // Idle searches after the last holder; busy searches after the current one,
  // which makes the current holder rank lowest while staying eligible.
  assign start_s      = IDW'(next_idx(int'(busy_s ? grant_id_q : last_id_q), NUM_REQ));

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i (req_valid_i),
    .start_i (start_s),
    .pick_o  (pick_s),
    .found_o (found_s)
  );

  // Select the granted requester's data slice (data path only).
  always_comb begin
    gnt_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_data_s = (grant_id_q == IDW'(i)) ? req_data_i[i*DATA_WIDTH +: DATA_WIDTH] : gnt_data_s;
    end
  end

  assign w_en_o        = accept_s;
  assign wdata_o       = accept_s ? gnt_data_s : '0;
  assign req_ready_o   = accept_s ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign grant_valid_o = busy_s;
  assign grant_id_o    = grant_id_q;

  // Arbiter FSM: idle pick, burst counting, release and same-cycle handover.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      last_id_q  <= IDW'(NUM_REQ - 1);
`ifdef WR_ARB_BURST_EN
      beat_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (found_s) begin
            state_q    <= ARB_BUSY;
            grant_id_q <= pick_s;
`ifdef WR_ARB_BURST_EN
            beat_cnt_q <= '0;
`endif
          end
        end
        ARB_BUSY: begin
          if (release_s) begin
            last_id_q <= grant_id_q;
`ifdef WR_ARB_BURST_EN
            beat_cnt_q <= '0;
`endif
            if (found_s) begin
              grant_id_q <= pick_s;
            end else begin
              state_q <= ARB_IDLE;
            end
          end else begin
`ifdef WR_ARB_BURST_EN
            if (accept_s) begin
              beat_cnt_q <= beat_cnt_q + CW'(1);
            end
`endif
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
